cla_sub16_pipe: RTL and testbench

CLA_SUB16_PIPE -- requirements
Module: cla_sub16_pipe

---
 rtl/cla_sub_pkg.sv | 18 +
 rtl/sub_prefix_cell.sv | 16 +
 rtl/cla_sub16_pipe.sv | 153 +++++++++++++++
 tb/tb_cla_sub16_pipe.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cla_sub_pkg.sv
// Shared types and constants for the pipelined 16-bit Kogge-Stone subtractor.
//   CLA_W       : datapath width
//   CLA_SUB_LAT : register stages between operand accept and result
//   gp_t        : generate/propagate pair
//   gp_vec_t    : one gp_t per bit position
package cla_sub_pkg;

    localparam int CLA_W       = 16;
    localparam int CLA_SUB_LAT = 3;

    typedef struct packed {
        logic g;
        logic p;
    } gp_t;

    typedef gp_t [CLA_W-1:0] gp_vec_t;

endpackage

// File: rtl/sub_prefix_cell.sv
// Kogge-Stone prefix combine cell.
//   cur  : group (g,p) of the more significant span
//   prev : group (g,p) of the adjacent less significant span
//   res  : merged group covering both spans
module sub_prefix_cell
    import cla_sub_pkg::*;
(
    input  gp_t cur,
    input  gp_t prev,
    output gp_t res
);

    assign res.g = cur.g | (cur.p & prev.g);
    assign res.p = cur.p & prev.p;

endmodule

// File: rtl/cla_sub16_pipe.sv
// Three-stage pipelined 16-bit subtractor, D = X - Y mod 2^16, computed as
// X + ~Y + 1 with a Kogge-Stone prefix network.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid / in_ready : operand handshake (X minuend, Y subtrahend)
//   out_valid/out_ready : result handshake (D difference, Bo borrow-out)
//   ovf                 : signed overflow, present only when CLA_SUB_OVF_EN
//                         is defined
// Stage 1 holds bitwise g/p, stage 2 prefix spans 1-2, stage 3 spans 4-8
// plus the final sum. Stages advance bubble-collapsing style.
module cla_sub16_pipe
    import cla_sub_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [CLA_W-1:0] X,
    input  logic [CLA_W-1:0] Y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CLA_W-1:0] D,
    output logic             Bo
`ifdef CLA_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    logic [3:1] vld_pipe;
    logic       adv1, adv2, adv3;

    // A stage moves when empty or when the stage after it moves.
    assign adv3      = ~vld_pipe[3] | out_ready;
    assign adv2      = ~vld_pipe[2] | adv3;
    assign adv1      = ~vld_pipe[1] | adv2;
    assign in_ready  = adv1;
    assign out_valid = vld_pipe[3];

    // Stage 1 input: bitwise g/p of X + ~Y. The forced carry-in is folded
    // into bit 0, so g0 = x0&~y0 | (x0^~y0)&1 = x0|~y0.
    gp_vec_t          gp0;
    logic [CLA_W-1:0] hx0;

    assign hx0 = X ^ ~Y;

    always_comb begin
        for (int i = 0; i < CLA_W; i++) begin
            gp0[i].g = X[i] & ~Y[i];
            gp0[i].p = hx0[i];
        end
        gp0[0].g = X[0] | ~Y[0];
    end

    gp_vec_t          s1_gp, s2_gp;
    logic [CLA_W-1:0] s1_hx, s2_hx;
    gp_vec_t          lv1, lv2, lv3, lv4;

    // Prefix levels: spans 1,2 feed stage 2; spans 4,8 feed stage 3.
    for (genvar i = 0; i < CLA_W; i++) begin : g_bit
        if (i >= 1) begin : g_l1
            sub_prefix_cell u_cell (.cur(s1_gp[i]), .prev(s1_gp[i-1]), .res(lv1[i]));
        end else begin : g_l1_pass
            assign lv1[i] = s1_gp[i];
        end
        if (i >= 2) begin : g_l2
            sub_prefix_cell u_cell (.cur(lv1[i]), .prev(lv1[i-2]), .res(lv2[i]));
        end else begin : g_l2_pass
            assign lv2[i] = lv1[i];
        end
        if (i >= 4) begin : g_l3
            sub_prefix_cell u_cell (.cur(s2_gp[i]), .prev(s2_gp[i-4]), .res(lv3[i]));
        end else begin : g_l3_pass
            assign lv3[i] = s2_gp[i];
        end
        if (i >= 8) begin : g_l4
            sub_prefix_cell u_cell (.cur(lv3[i]), .prev(lv3[i-8]), .res(lv4[i]));
        end else begin : g_l4_pass
            assign lv4[i] = lv3[i];
        end
    end

    // gcar[i] is the carry out of bit i (group generate over [i:0]).
    logic [CLA_W-1:0] gcar;
    logic [CLA_W-1:0] sum;
    logic             unused_lv4_p;

    always_comb begin
        unused_lv4_p = 1'b0;
        for (int i = 0; i < CLA_W; i++) begin
            gcar[i]      = lv4[i].g;
            unused_lv4_p = unused_lv4_p ^ lv4[i].p;
        end
    end

    assign sum = s2_hx ^ {gcar[CLA_W-2:0], 1'b1};

`ifdef CLA_SUB_OVF_EN
    logic s1_xs, s1_ys, s2_xs, s2_ys;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            s1_gp    <= '0;
            s1_hx    <= '0;
            s2_gp    <= '0;
            s2_hx    <= '0;
            D        <= '0;
            Bo       <= 1'b0;
`ifdef CLA_SUB_OVF_EN
            s1_xs    <= 1'b0;
            s1_ys    <= 1'b0;
            s2_xs    <= 1'b0;
            s2_ys    <= 1'b0;
            ovf      <= 1'b0;
`endif
        end else begin
            if (adv1) begin
                vld_pipe[1] <= in_valid;
                if (in_valid) begin
                    s1_gp <= gp0;
                    s1_hx <= hx0;
`ifdef CLA_SUB_OVF_EN
                    s1_xs <= X[CLA_W-1];
                    s1_ys <= Y[CLA_W-1];
`endif
                end
            end
            if (adv2) begin
                vld_pipe[2] <= vld_pipe[1];
                if (vld_pipe[1]) begin
                    s2_gp <= lv2;
                    s2_hx <= s1_hx;
`ifdef CLA_SUB_OVF_EN
                    s2_xs <= s1_xs;
                    s2_ys <= s1_ys;
`endif
                end
            end
            if (adv3) begin
                vld_pipe[3] <= vld_pipe[2];
                if (vld_pipe[2]) begin
                    D  <= sum;
                    Bo <= ~gcar[CLA_W-1];
`ifdef CLA_SUB_OVF_EN
                    ovf <= (s2_xs != s2_ys) && (sum[CLA_W-1] != s2_xs);
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_cla_sub16_pipe.sv
// Self-checking bench for cla_sub16_pipe: directed vector table, hand-written
// backpressure and reset sequences, then randomized traffic against an
// arithmetic reference model and an in-order expectation queue.
module tb_cla_sub16_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] X, Y;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] D;
    logic        Bo;
`ifdef CLA_SUB_OVF_EN
    logic        ovf;
`endif

    cla_sub16_pipe dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .X        (X),
        .Y        (Y),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .D        (D),
        .Bo       (Bo)
`ifdef CLA_SUB_OVF_EN
        ,
        .ovf      (ovf)
`endif
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: plain integer arithmetic.
    typedef struct packed {
        logic [15:0] d;
        logic        bo;
        logic        ov;
    } exp_t;

    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b);
        exp_t e;
        int   sd;
        e.d  = 16'(int'(a) - int'(b));
        e.bo = (int'(a) < int'(b));
        sd   = int'($signed(a)) - int'($signed(b));
        e.ov = (sd > 32767) || (sd < -32768);
        return e;
    endfunction

    // Monitor: tracks accepted operands in order and checks every emitted
    // result, the expected in_ready, and output stability under stall.
    exp_t q[$];

    initial begin : monitor
        exp_t        e;
        logic        prev_stall;
        logic [15:0] prev_d;
        logic        prev_bo;
        prev_stall = 1'b0;
        prev_d     = '0;
        prev_bo    = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                q.delete();
                prev_stall = 1'b0;
            end else begin
                chk("in_ready_occupancy", in_ready, (q.size() < 3) || out_ready);
                if (prev_stall) begin
                    chk("stall_hold_valid", out_valid, 1);
                    chk("stall_hold_d", D, prev_d);
                    chk("stall_hold_bo", Bo, prev_bo);
                end
                if (out_valid) chk("out_valid_has_item", q.size() != 0, 1);
                if (out_valid && out_ready && q.size() != 0) begin
                    e = q.pop_front();
                    chk("model_d", D, e.d);
                    chk("model_bo", Bo, e.bo);
`ifdef CLA_SUB_OVF_EN
                    chk("model_ovf", ovf, e.ov);
`endif
                end
                if (in_valid && in_ready) q.push_back(model(X, Y));
                prev_stall = out_valid && !out_ready;
                prev_d     = D;
                prev_bo    = Bo;
            end
        end
    end

    // One beat on an empty pipe; checks latency and the result.
    task automatic single_beat(input logic [15:0] x, input logic [15:0] y,
                               input logic [15:0] ed, input logic ebo,
                               input logic eov, input string name);
        int lat;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b1; X = x; Y = y;
        @(negedge clk);
        chk({name, "_in_ready"}, in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0; X = 16'($urandom); Y = 16'($urandom);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 8);
        chk({name, "_latency"}, lat, 3);
        chk({name, "_d"}, D, ed);
        chk({name, "_bo"}, Bo, ebo);
`ifdef CLA_SUB_OVF_EN
        chk({name, "_ovf"}, ovf, eov);
`else
        if (eov === 1'bx) $display("unexpected x in table");
`endif
        @(posedge clk); #1;
    endtask

    function automatic logic [15:0] pick16();
        case ($urandom % 8)
            0:       return 16'h0000;
            1:       return 16'hFFFF;
            2:       return 16'h8000;
            3:       return 16'h7FFF;
            default: return 16'($urandom);
        endcase
    endfunction

    typedef struct {
        logic [15:0] x, y, d;
        logic        bo, ov;
        string       name;
    } vec_t;

    vec_t tbl[7];

    initial begin : main
        int          n, sent, cyc, lim;
        logic        acc;
        logic [15:0] got[16];

        tbl[0] = '{16'h0005, 16'h0003, 16'h0002, 1'b0, 1'b0, "v5m3"};
        tbl[1] = '{16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1'b0, "v0m1"};
        tbl[2] = '{16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 1'b0, "vffmff"};
        tbl[3] = '{16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1, "v8000m1"};
        tbl[4] = '{16'h7FFF, 16'hFFFF, 16'h8000, 1'b1, 1'b1, "v7fffmffff"};
        tbl[5] = '{16'h1234, 16'h1234, 16'h0000, 1'b0, 1'b0, "veq"};
        tbl[6] = '{16'h0000, 16'hFFFF, 16'h0001, 1'b1, 1'b0, "v0mffff"};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; X = '0; Y = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_in_ready", in_ready, 1);
        chk("reset_d", D, 0);
        chk("reset_bo", Bo, 0);
`ifdef CLA_SUB_OVF_EN
        chk("reset_ovf", ovf, 0);
`endif

        for (int i = 0; i < 7; i++)
            single_beat(tbl[i].x, tbl[i].y, tbl[i].d, tbl[i].bo, tbl[i].ov, tbl[i].name);

        // Backpressure: three pairs fill the pipe, the fourth waits.
        out_ready = 1'b0;
        @(posedge clk); #1; in_valid = 1'b1; X = 16'd1; Y = 16'd1;
        @(posedge clk); #1; X = 16'd2;
        @(posedge clk); #1; X = 16'd3;
        @(posedge clk); #1; X = 16'd4;
        @(negedge clk);
        chk("bp_full_in_ready", in_ready, 0);
        chk("bp_full_out_valid", out_valid, 1);
        chk("bp_full_d", D, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_hold_in_ready", in_ready, 0);
        chk("bp_hold_d", D, 0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        n = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (out_valid && n < 16) begin got[n] = D; n++; end
            @(posedge clk); #1;
            in_valid = 1'b0;
        end
        chk("bp_count", n, 4);
        for (int k = 0; k < 4; k++) chk("bp_order", got[k], k);

        // Reset with two results in flight; neither may appear.
        @(posedge clk); #1; in_valid = 1'b1; X = 16'd7; Y = 16'd1;
        @(posedge clk); #1; X = 16'd8; Y = 16'd2;
        @(posedge clk); #1; in_valid = 1'b0; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("rst_flush_out_valid", out_valid, 0);
        end
        single_beat(16'd9, 16'd4, 16'd5, 1'b0, 1'b0, "after_rst");

        // Random traffic with random backpressure.
        sent = 0; cyc = 0; acc = 1'b0;
        while (sent < 10000 && cyc < 60000) begin
            @(posedge clk); #1;
            cyc++;
            out_ready = ($urandom % 4) != 0;
            if (!in_valid || acc) begin
                in_valid = ($urandom % 4) != 0;
                X = pick16();
                Y = pick16();
            end
            @(negedge clk);
            acc = in_valid && in_ready;
            if (acc) sent++;
        end
        chk("random_sent", sent, 10000);
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b1;
        lim = 0;
        while (q.size() != 0 && lim < 20) begin
            @(negedge clk);
            lim++;
        end
        chk("drain_empty", q.size(), 0);
        @(negedge clk);
        chk("drain_out_valid", out_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
